// File: rtl/neuron_loader_pkg.sv
// Shared types and defaults for the neuron layer loader.
package neuron_loader_pkg;

  typedef enum logic [1:0] {
    NL_IDLE,
    NL_LOAD,
    NL_FILL,
    NL_DONE
  } nl_state_e;

  localparam int unsigned DefaultDataW = 16;
  localparam int unsigned DefaultAddrW = 16;

  // Beat counter must hold 0..num_neurons.
  function automatic int unsigned cnt_width(input int unsigned num_neurons);
    return unsigned'($clog2(num_neurons + 1));
  endfunction

endpackage

// File: rtl/neuron_layer_loader.sv
// Streams len words into a neuron layer as registered writes at base+cnt.
// Define NEURON_LOADER_ZERO_FILL_EN to zero-fill the remaining addresses on an early in_last.
module neuron_layer_loader
  import neuron_loader_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 2,
  parameter int unsigned DATA_W      = DefaultDataW,
  parameter int unsigned ADDR_W      = DefaultAddrW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              load_en,
  output logic [ADDR_W-1:0] load_address,
  output logic [DATA_W-1:0] load_value,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CntW = cnt_width(NUM_NEURONS);

  nl_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CntW-1:0]   len_q, len_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   len_m1;
  logic              err_q, err_d;
  logic              load_en_q, load_en_d;
  logic [ADDR_W-1:0] load_address_q, load_address_d;
  logic [DATA_W-1:0] load_value_q, load_value_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              beat;
  logic              final_beat;

  assign in_ready   = (state_q == NL_LOAD);
  assign beat       = in_valid & in_ready;
  assign len_m1     = len_q - CntW'(1);
  assign final_beat = (cnt_q == len_m1);

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    load_en_d      = 1'b0;
    load_address_d = load_address_q;
    load_value_d   = load_value_q;

    unique case (state_q)
      NL_IDLE: begin
        if (start) begin
          base_d = base_addr;
          cnt_d  = '0;
          err_d  = 1'b0;
          if (len == '0) begin
            len_d   = '0;
            state_d = NL_DONE;
          end else begin
            len_d   = (len > ADDR_W'(NUM_NEURONS)) ? CntW'(NUM_NEURONS) : CntW'(len);
            state_d = NL_LOAD;
          end
        end
      end

      NL_LOAD: begin
        if (beat) begin
          load_en_d      = 1'b1;
          load_address_d = base_q + ADDR_W'(cnt_q);
          load_value_d   = in_data;
          cnt_d          = cnt_q + CntW'(1);
          if (final_beat) begin
            err_d   = ~in_last;
            state_d = NL_DONE;
          end else if (in_last) begin
`ifdef NEURON_LOADER_ZERO_FILL_EN
            state_d = NL_FILL;
`else
            err_d   = 1'b1;
            state_d = NL_DONE;
`endif
          end
        end
      end

`ifdef NEURON_LOADER_ZERO_FILL_EN
      NL_FILL: begin
        load_en_d      = 1'b1;
        load_address_d = base_q + ADDR_W'(cnt_q);
        load_value_d   = '0;
        if (final_beat) begin
          state_d = NL_DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif

      NL_DONE: state_d = NL_IDLE;

      default: state_d = NL_IDLE;
    endcase

    busy_d = (state_d != NL_IDLE);
    // Pulse one cycle after DONE so the final write has already landed.
    done_d = (state_q == NL_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= NL_IDLE;
      base_q         <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      err_q          <= 1'b0;
      load_en_q      <= 1'b0;
      load_address_q <= '0;
      load_value_q   <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      load_en_q      <= load_en_d;
      load_address_q <= load_address_d;
      load_value_q   <= load_value_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign load_en      = load_en_q;
  assign load_address = load_address_q;
  assign load_value   = load_value_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_neuron_layer_loader.sv
// Directed bench for neuron_layer_loader: a write-list model checked on every write and done pulse.
module tb_neuron_layer_loader;

  localparam int N = 2;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        load_en;
  logic [15:0] load_address;
  logic [15:0] load_value;
  logic        busy;
  logic        done;
  logic        err;

  neuron_layer_loader #(
    .NUM_NEURONS(N),
    .DATA_W     (16),
    .ADDR_W     (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .len         (len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .load_en     (load_en),
    .load_address(load_address),
    .load_value  (load_value),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [15:0] d;
    bit          last;
    int          gap;
  } word_t;

  int    passed = 0;
  int    total = 0;
  int    cyc = 0;
  int    done_seen = 0;
  int    done_cyc = 0;
  int    start_cyc = 0;
  bit    exp_pending = 0;
  bit    exp_err = 0;
  wr_t   exp_q[$];
  wr_t   obs[$];
  int    obs_cyc[$];
  word_t words[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Compare process: every write and done pulse is checked against the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (load_en) begin
        wr_t w;
        w.a = load_address;
        w.d = load_value;
        obs.push_back(w);
        obs_cyc.push_back(cyc);
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("write_addr", 32'(load_address), 32'(exp_q[0].a));
          check("write_value", 32'(load_value), 32'(exp_q[0].d));
          void'(exp_q.pop_front());
        end
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
        check("done_expected", 32'(exp_pending), 32'd1);
        check("done_writes_left", 32'(exp_q.size()), 32'd0);
        check("done_err", 32'(err), 32'(exp_err));
        exp_pending = 0;
      end
    end
  end

  task automatic add_word(input logic [15:0] d, input bit last, input int gap);
    word_t w;
    w.d = d;
    w.last = last;
    w.gap = gap;
    words.push_back(w);
  endtask

  // Called at #1 after a rising edge with the DUT idle.
  task automatic run(input logic [15:0] b, input logic [15:0] l, input bit gap_start);
    int  eff;
    int  n_feed;
    int  k;
    int  d0;
    bit  rdy;
    wr_t w;
    eff = (l > 16'(N)) ? N : int'(l);
    exp_q.delete();
    obs.delete();
    obs_cyc.delete();
    exp_err = 0;
    n_feed = 0;
    for (int i = 0; i < eff && i < words.size(); i++) begin
      w.a = b + 16'(i);
      w.d = words[i].d;
      exp_q.push_back(w);
      n_feed = i + 1;
      if (i == eff - 1) begin
        exp_err = !words[i].last;
        break;
      end
      if (words[i].last) begin
`ifdef NEURON_LOADER_ZERO_FILL_EN
        for (int j = i + 1; j < eff; j++) begin
          w.a = b + 16'(j);
          w.d = 16'h0000;
          exp_q.push_back(w);
        end
        exp_err = 0;
`else
        exp_err = 1;
`endif
        break;
      end
    end
    exp_pending = 1;
    d0 = done_seen;

    start_cyc = cyc;
    start = 1'b1;
    base_addr = b;
    len = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ready_t1", 32'(in_ready), 32'(eff > 0));
    check("busy_t1", 32'(busy), 32'd1);

    for (int i = 0; i < n_feed; i++) begin
      for (int g = 0; g < words[i].gap; g++) begin
        in_valid = 1'b0;
        if (gap_start) begin
          start = 1'b1;
          base_addr = 16'h0077;
          len = 16'd1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data = words[i].d;
      in_last = words[i].last;
      k = 0;
      do begin
        rdy = in_ready;
        @(posedge clk);
        #1;
        k++;
      end while (!rdy && k < 20);
      if (!rdy) check("beat_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      in_last = 1'b0;
    end

    k = 0;
    while (done_seen == d0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 32'(done_seen != d0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_load_en", 32'(load_en), 32'd0);
    check("rst_addr", 32'(load_address), 32'd0);
    check("rst_value", 32'(load_value), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Nominal
    words.delete();
    add_word(16'h1234, 0, 0);
    add_word(16'hABCD, 1, 0);
    run(16'h0000, 16'd2, 0);
    check("nom_n", 32'(obs.size()), 32'd2);
    check("nom_w0", 32'(obs[0]), 32'h0000_1234);
    check("nom_w1", 32'(obs[1]), 32'h0001_ABCD);
    check("nom_consec", 32'(obs_cyc[1] - obs_cyc[0]), 32'd1);
    check("nom_done_lat", 32'(done_cyc - obs_cyc[1]), 32'd1);
    check("nom_err", 32'(err), 32'd0);
    check("nom_idle_ready", 32'(in_ready), 32'd0);
    check("nom_idle_busy", 32'(busy), 32'd0);

    // Missing in_last
    words.delete();
    add_word(16'h0101, 0, 0);
    add_word(16'h0202, 0, 0);
    run(16'h0000, 16'd2, 0);
    check("miss_n", 32'(obs.size()), 32'd2);
    check("miss_err", 32'(err), 32'd1);

    // Early in_last
    words.delete();
    add_word(16'h5555, 1, 0);
    run(16'h0000, 16'd2, 0);
    check("early_w0", 32'(obs[0]), 32'h0000_5555);
`ifdef NEURON_LOADER_ZERO_FILL_EN
    check("early_n", 32'(obs.size()), 32'd2);
    check("early_w1", 32'(obs[1]), 32'h0001_0000);
    check("early_err", 32'(err), 32'd0);
`else
    check("early_n", 32'(obs.size()), 32'd1);
    check("early_err", 32'(err), 32'd1);
`endif

    // Backpressure with a start pulse during the stall
    words.delete();
    add_word(16'h0A0A, 0, 0);
    add_word(16'h0B0B, 1, 1);
    run(16'h0020, 16'd2, 1);
    check("bp_n", 32'(obs.size()), 32'd2);
    check("bp_w0", 32'(obs[0]), 32'h0020_0A0A);
    check("bp_w1", 32'(obs[1]), 32'h0021_0B0B);
    check("bp_err", 32'(err), 32'd0);

    // Address wrap
    words.delete();
    add_word(16'hC0DE, 0, 0);
    add_word(16'hBEEF, 1, 0);
    run(16'hFFFF, 16'd2, 0);
    check("wrap_w0", 32'(obs[0]), 32'hFFFF_C0DE);
    check("wrap_w1", 32'(obs[1]), 32'h0000_BEEF);

    // Zero length
    words.delete();
    run(16'h0005, 16'd0, 0);
    check("zero_n", 32'(obs.size()), 32'd0);
    check("zero_done_t2", 32'(done_cyc - start_cyc), 32'd2);
    check("zero_err", 32'(err), 32'd0);

    // Oversized len clamps to N
    words.delete();
    add_word(16'h1111, 0, 0);
    add_word(16'h2222, 1, 0);
    run(16'h0100, 16'd5, 0);
    check("clamp_n", 32'(obs.size()), 32'd2);
    check("clamp_w1", 32'(obs[1]), 32'h0101_2222);
    check("clamp_err", 32'(err), 32'd0);

    // Reset after the first beat drops the in-flight write
    obs.delete();
    exp_q.delete();
    exp_pending = 0;
    start = 1'b1;
    base_addr = 16'h0010;
    len = 16'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h1111;
    in_last = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mid_inflight", 32'(load_en), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_load_en", 32'(load_en), 32'd0);
    check("mid_addr", 32'(load_address), 32'd0);
    check("mid_value", 32'(load_value), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    d0 = done_seen;
    repeat (6) @(posedge clk);
    #1;
    check("mid_no_done", 32'(done_seen), 32'(d0));
    check("mid_no_write", 32'(obs.size()), 32'd0);

    words.delete();
    add_word(16'h1234, 0, 0);
    add_word(16'hABCD, 1, 0);
    run(16'h0000, 16'd2, 0);
    check("post_w0", 32'(obs[0]), 32'h0000_1234);
    check("post_w1", 32'(obs[1]), 32'h0001_ABCD);
    check("post_err", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/neuron_layer_loader.md
# neuron_layer_loader

Sequencing controller that fills a neuron layer's value registers from a streaming source. Accepts a load command (base address, length), consumes `len` words over a valid/ready stream, and issues one registered write per word on the layer's `load_en`/`load_address`/`load_value` port. It sits between the weight/activation fetch path and the neuron layer, and signals completion and stream-framing errors to the top-level sequencer.

## Interface
- `NUM_NEURONS`, 2: largest legal `len`; sizes the beat counter.
- `DATA_W`, 16: width of stream data and `load_value`.
- `ADDR_W`, 16: width of `base_addr`, `len` and `load_address`.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first layer address; captured on accepted `start`.
- `len`  in  ADDR_W  word count, 0..NUM_NEURONS; captured on accepted `start`.
- `in_valid`  in  1  stream word valid.
- `in_ready`  out  1  controller can accept a word.
- `in_data`  in  DATA_W  stream word.
- `in_last`  in  1  final word of the stream frame.
- `load_en`  out  1  write strobe to the layer.
- `load_address`  out  ADDR_W  write address.
- `load_value`  out  DATA_W  write data.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  framing error for the last command; valid from the `done` pulse until the next accepted `start`.

## Operation
- States: IDLE, LOAD, FILL (only with the macro), DONE.
- IDLE: `in_ready`=0. On `start`=1:
  - `len`=0 -> DONE, no writes.
  - `len`>NUM_NEURONS -> clamp to NUM_NEURONS.
  - Otherwise capture base and len, clear `cnt` and `err`, go to LOAD.
- LOAD: `in_ready`=1. A beat is `in_valid & in_ready`. Each beat registers `load_en`=1, `load_address`=base+cnt, `load_value`=`in_data`, then increments `cnt`.
  - Final beat (cnt==len-1) -> DONE. `err`=1 if `in_last`=0 on that beat.
  - Early `in_last` (cnt<len-1) -> see Configuration.
- FILL: `in_ready`=0. One zero write per cycle at base+cnt until cnt==len-1, then DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- `start` outside IDLE is ignored. A word is never accepted outside LOAD.
- Address arithmetic is base+cnt modulo 2^ADDR_W; wrap is silent.
- `load_en` is 0 on every cycle without a write, and `load_address`/`load_value` hold their last values.

## Timing
- All outputs are registered except `in_ready`, which decodes the registered state.
- Reset values: `load_en`=0, `load_address`=0, `load_value`=0, `in_ready`=0, `busy`=0, `done`=0, `err`=0. State returns to IDLE.
- Start to LOAD: `start` at cycle t gives `in_ready`=1 at t+1.
- Write latency: a beat at cycle k drives `load_en`=1 at k+1. Back-to-back beats give consecutive writes.
- `done` rises the cycle after the final write is issued, so the layer has already captured the last word.
- `len`=0: `done` at t+2 with no writes.
- Reset mid-operation: any in-flight write is dropped, no `done` is issued, and the controller waits for a fresh `start`.

## Configuration
- `NEURON_LOADER_ZERO_FILL_EN` defined: an early `in_last` moves the controller to FILL, which writes zero to every remaining address. `err` stays 0.
- Not defined: an early `in_last` goes straight to DONE with `err`=1, and remaining addresses are untouched. The FILL state is not compiled.

## Structure
- Package `neuron_loader_pkg` holds:
  - the state enum (`NL_IDLE`, `NL_LOAD`, `NL_FILL`, `NL_DONE`);
  - default `DATA_W`/`ADDR_W` constants;
  - a `cnt` width function, $clog2(NUM_NEURONS+1).
- No sub-module: one FSM plus counter plus output registers.

## Test plan
- Nominal: base=0, len=2, words 0x1234 then 0xABCD with `in_last` on the second -> writes (0,0x1234) and (1,0xABCD) on consecutive cycles, then `done`, `err`=0.
- Missing last: len=2, `in_last`=0 on both beats -> two writes, then `done` with `err`=1.
- Early last: len=2, first word 0x5555 with `in_last`=1 -> with macro, writes (0,0x5555) and (1,0x0000), `err`=0. Without macro, single write, then `done` with `err`=1.
- Backpressure and ignored start: `in_valid` toggling 1,0,1 and `start` pulsed during LOAD -> exactly `len` writes, with the command unchanged.
- Wrap and zero length: base=0xFFFF, len=2 -> writes at 0xFFFF then 0x0000. len=0 -> `done` at t+2 with no `load_en`.
- Reset mid-operation: `reset` asserted after the first beat -> all outputs 0 immediately, no `done`. A new `start` then runs the nominal case correctly.
